// File: rtl/control_execute.sv
// control_execute: execute-stage sequencer for the DEC/EXE -> EXE/WB pipeline.
// Accepts one op from the DEC/EXE buffer, runs it as ALU, memory or
// multi-cycle, stalls decode for non-ALU ops and releases it on completion.
// Optional feature: define EXE_MEM_TIMEOUT_EN to abort a memory access that
// has not completed by its 16th cycle (raises MemErr, releases decode).
module control_execute (
   input  logic       CLK,
   input  logic       RST,
   input  logic       DecExeValid,
   input  logic [1:0] OpClass,
   input  logic [3:0] MulCycles,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       MemWr,
   output logic       AluStart,
   output logic       ExeWbBufferWr,
   output logic       SetStallDec,
   output logic       ClrStallDec,
   output logic       IsExeBusy,
   output logic       ExeOverrun,
   output logic       MemErr
);

   typedef enum logic [2:0] {
      EXE_IDLE = 3'd0,
      EXE_ALU  = 3'd1,
      EXE_MEM  = 3'd2,
      EXE_MUL  = 3'd3,
      EXE_WB   = 3'd4
   } exeState_t;

   exeState_t  r_state;
   exeState_t  w_nextState;
   logic [1:0] r_opClass;
   logic [3:0] r_mulCnt;
   logic       r_mulFirst;
   logic       r_overrun;
`ifdef EXE_MEM_TIMEOUT_EN
   logic [3:0] r_memCnt;
`endif

   logic w_memReq;
   logic w_memWr;
   logic w_aluStart;
   logic w_exeWbBufferWr;
   logic w_setStallDec;
   logic w_clrStallDec;
   logic w_memErr;

   // State register; reset always returns to idle so an aborted op never completes
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= EXE_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Latched op, multi-cycle down-counter and the sticky overrun flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_opClass  <= 2'b00;
         r_mulCnt   <= 4'd0;
         r_mulFirst <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (r_state == EXE_IDLE && DecExeValid) begin
            r_opClass  <= OpClass;
            r_mulCnt   <= (MulCycles == 4'd0) ? 4'd1 : MulCycles;
            r_mulFirst <= 1'b1;
         end
         if (r_state == EXE_MUL) begin
            r_mulFirst <= 1'b0;
            r_mulCnt   <= r_mulCnt - 4'd1;
         end
         if (r_state != EXE_IDLE && DecExeValid) begin
            r_overrun <= 1'b1;
         end
      end
   end

`ifdef EXE_MEM_TIMEOUT_EN
   // Counts consecutive memory-wait cycles; zero in the first EXE_MEM cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_memCnt <= 4'd0;
      end else if (r_state == EXE_MEM) begin
         r_memCnt <= r_memCnt + 4'd1;
      end else begin
         r_memCnt <= 4'd0;
      end
   end
`endif

   // Next-state and output decode; reset overrides everything, including the
   // combinational stall request raised in the acceptance cycle
   always_comb begin
      w_nextState     = r_state;
      w_memReq        = 1'b0;
      w_memWr         = 1'b0;
      w_aluStart      = 1'b0;
      w_exeWbBufferWr = 1'b0;
      w_setStallDec   = 1'b0;
      w_clrStallDec   = 1'b0;
      w_memErr        = 1'b0;
      case (r_state)
         EXE_IDLE: begin
            if (DecExeValid) begin
               w_setStallDec = (OpClass != 2'b00);
               case (OpClass)
                  2'b00:   w_nextState = EXE_ALU;
                  2'b11:   w_nextState = EXE_MUL;
                  default: w_nextState = EXE_MEM;
               endcase
            end
         end
         EXE_ALU: begin
            w_aluStart      = 1'b1;
            w_exeWbBufferWr = 1'b1;
            w_nextState     = EXE_IDLE;
         end
         EXE_MEM: begin
            w_memReq = 1'b1;
            w_memWr  = (r_opClass == 2'b10);
            if (MemReady) begin
               w_nextState = EXE_WB;
            end
`ifdef EXE_MEM_TIMEOUT_EN
            else if (r_memCnt == 4'd15) begin
               w_memErr      = 1'b1;
               w_clrStallDec = 1'b1;
               w_nextState   = EXE_IDLE;
            end
`endif
         end
         EXE_MUL: begin
            w_aluStart = r_mulFirst;
            if (r_mulCnt <= 4'd1) begin
               w_nextState = EXE_WB;
            end
         end
         EXE_WB: begin
            w_exeWbBufferWr = 1'b1;
            w_clrStallDec   = 1'b1;
            w_nextState     = EXE_IDLE;
         end
         default: begin
            w_nextState = EXE_IDLE;
         end
      endcase
      if (RST) begin
         w_nextState     = EXE_IDLE;
         w_memReq        = 1'b0;
         w_memWr         = 1'b0;
         w_aluStart      = 1'b0;
         w_exeWbBufferWr = 1'b0;
         w_setStallDec   = 1'b0;
         w_clrStallDec   = 1'b0;
         w_memErr        = 1'b0;
      end
   end

   assign MemReq        = w_memReq;
   assign MemWr         = w_memWr;
   assign AluStart      = w_aluStart;
   assign ExeWbBufferWr = w_exeWbBufferWr;
   assign SetStallDec   = w_setStallDec;
   assign ClrStallDec   = w_clrStallDec;
   assign MemErr        = w_memErr;
   assign IsExeBusy     = (r_state != EXE_IDLE) && !RST;
   assign ExeOverrun    = r_overrun && !RST;

endmodule

// File: tb/tb_control_execute.sv
// tb_control_execute: directed bench for control_execute.
// Outputs are packed as {MemReq, MemWr, AluStart, ExeWbBufferWr, SetStallDec,
// ClrStallDec, IsExeBusy, ExeOverrun, MemErr} and compared against hand-computed
// vectors one cycle at a time.
module tb_control_execute;

   logic       CLK;
   logic       RST;
   logic       DecExeValid;
   logic [1:0] OpClass;
   logic [3:0] MulCycles;
   logic       MemReady;
   logic       MemReq;
   logic       MemWr;
   logic       AluStart;
   logic       ExeWbBufferWr;
   logic       SetStallDec;
   logic       ClrStallDec;
   logic       IsExeBusy;
   logic       ExeOverrun;
   logic       MemErr;

   int checkCount = 0;
   int errorCount = 0;

   control_execute dut (
      .CLK           (CLK),
      .RST           (RST),
      .DecExeValid   (DecExeValid),
      .OpClass       (OpClass),
      .MulCycles     (MulCycles),
      .MemReady      (MemReady),
      .MemReq        (MemReq),
      .MemWr         (MemWr),
      .AluStart      (AluStart),
      .ExeWbBufferWr (ExeWbBufferWr),
      .SetStallDec   (SetStallDec),
      .ClrStallDec   (ClrStallDec),
      .IsExeBusy     (IsExeBusy),
      .ExeOverrun    (ExeOverrun),
      .MemErr        (MemErr)
   );

   // Free-running 10 ns clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected-output encodings
   localparam logic [8:0] IDLE0   = 9'b000000000;
   localparam logic [8:0] ACCEPT  = 9'b000010000;
   localparam logic [8:0] ALU     = 9'b001100100;
   localparam logic [8:0] LOADW   = 9'b100000100;
   localparam logic [8:0] STOREW  = 9'b110000100;
   localparam logic [8:0] WB      = 9'b000101100;
   localparam logic [8:0] MULST   = 9'b001000100;
   localparam logic [8:0] MULRUN  = 9'b000000100;

   function automatic logic [8:0] packOut();
      return {MemReq, MemWr, AluStart, ExeWbBufferWr, SetStallDec,
              ClrStallDec, IsExeBusy, ExeOverrun, MemErr};
   endfunction

   // Single comparison point for the whole bench
   task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic valid, input logic [1:0] op,
                                input logic [3:0] cycles, input logic ready);
      RST         = rst;
      DecExeValid = valid;
      OpClass     = op;
      MulCycles   = cycles;
      MemReady    = ready;
   endtask

   // Check the current cycle's outputs, then advance to just after the next edge
   task automatic expectCycle(input string tag, input logic [8:0] expected);
      #1;
      checkOutput(tag, packOut(), expected);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      applyStimulus(1'b1, 1'b1, 2'b11, 4'd5, 1'b1);
      @(posedge CLK);
      #1;

      // Reset held with a simultaneous valid: everything low, op not accepted
      applyStimulus(1'b1, 1'b1, 2'b11, 4'd5, 1'b1);
      expectCycle("reset_valid", IDLE0);
      applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("reset_hold", IDLE0);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("post_reset_idle", IDLE0);

      // ALU op: no stall, one-cycle start + writeback, then idle
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 1'b0);
      expectCycle("alu_accept", IDLE0);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("alu_exec", ALU);
      expectCycle("alu_done", IDLE0);

      // Load: ready arrives in the 4th memory cycle
      applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 1'b0);
      expectCycle("load_accept", ACCEPT);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         expectCycle($sformatf("load_wait%0d", i), LOADW);
      end
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
      expectCycle("load_ready", LOADW);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("load_wb", WB);
      expectCycle("load_done", IDLE0);

      // Store with a second op arriving mid-access: ignored, overrun sticks
      applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      expectCycle("store_accept", ACCEPT);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("store_wait", STOREW);
      applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 1'b0);
      expectCycle("overrun_no_stall", STOREW);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
      expectCycle("overrun_flag", 9'b110000110);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("store_wb", 9'b000101110);
      expectCycle("overrun_sticky1", 9'b000000010);
      expectCycle("overrun_sticky2", 9'b000000010);
      applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("overrun_reset", IDLE0);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("overrun_cleared", IDLE0);

      // Multi-cycle, 5 cycles; MemReady toggling must be ignored
      applyStimulus(1'b0, 1'b1, 2'b11, 4'd5, 1'b0);
      expectCycle("mul5_accept", ACCEPT);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd9, 1'b1);
      expectCycle("mul5_c1", MULST);
      for (int i = 2; i <= 5; i++) begin
         expectCycle($sformatf("mul5_c%0d", i), MULRUN);
      end
      expectCycle("mul5_wb", WB);
      expectCycle("mul5_done", IDLE0);

      // Multi-cycle with length 0 behaves as length 1
      applyStimulus(1'b0, 1'b1, 2'b11, 4'd0, 1'b0);
      expectCycle("mul0_accept", ACCEPT);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("mul0_c1", MULST);
      expectCycle("mul0_wb", WB);
      expectCycle("mul0_done", IDLE0);

      // Reset in the 2nd multi-cycle cycle aborts without a stall release
      applyStimulus(1'b0, 1'b1, 2'b11, 4'd5, 1'b0);
      expectCycle("abort_accept", ACCEPT);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("abort_c1", MULST);
      applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("abort_rst", IDLE0);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("abort_idle1", IDLE0);
      expectCycle("abort_idle2", IDLE0);

      // Store whose memory never answers
      applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      expectCycle("hang_accept", ACCEPT);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
`ifdef EXE_MEM_TIMEOUT_EN
      for (int i = 1; i <= 15; i++) begin
         expectCycle($sformatf("tmo_wait%0d", i), STOREW);
      end
      expectCycle("tmo_err", 9'b110001101);
      expectCycle("tmo_idle", IDLE0);

      // Ready exactly in the 16th cycle completes normally
      applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 1'b0);
      expectCycle("tmo16_accept", ACCEPT);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         expectCycle($sformatf("tmo16_wait%0d", i), STOREW);
      end
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
      expectCycle("tmo16_ready", STOREW);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("tmo16_wb", WB);
      expectCycle("tmo16_done", IDLE0);
`else
      for (int i = 1; i <= 100; i++) begin
         expectCycle($sformatf("hang_wait%0d", i), STOREW);
      end
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b1);
      expectCycle("hang_ready", STOREW);
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
      expectCycle("hang_wb", WB);
      expectCycle("hang_done", IDLE0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/control_execute.md
CONTROL_EXECUTE -- requirements
Module: control_execute

Interface
REQ-001 SHALL have port: CLK  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: DecExeValid  input  1  one-cycle pulse; DEC/EXE buffer written this cycle (driven from decode DecExeBufferWr).
REQ-004 SHALL have port: OpClass  input  2  class of the op in DEC/EXE buffer: 00 ALU, 01 load, 10 store, 11 multi-cycle.
REQ-005 SHALL have port: MulCycles  input  4  execution length of a class-11 op in cycles; value 0 is treated as 1.
REQ-006 SHALL have port: MemReady  input  1  memory completion handshake.
REQ-007 SHALL have port: MemReq  output  1  memory request.
REQ-008 SHALL have port: MemWr  output  1  request is a write; valid only with MemReq.
REQ-009 SHALL have port: AluStart  output  1  one-cycle ALU/multiplier start strobe.
REQ-010 SHALL have port: ExeWbBufferWr  output  1  write EXE/WB buffer.
REQ-011 SHALL have port: SetStallDec  output  1  place the decode state machine in stall.
REQ-012 SHALL have port: ClrStallDec  output  1  release the decode stall.
REQ-013 SHALL have port: IsExeBusy  output  1  high in every state except EXE_IDLE.
REQ-014 SHALL have port: ExeOverrun  output  1  sticky; DecExeValid arrived while busy.
REQ-015 SHALL have port: MemErr  output  1  memory timeout pulse (see Configuration).

Function
REQ-016 SHALL implement states EXE_IDLE, EXE_ALU, EXE_MEM, EXE_MUL, EXE_WB.
REQ-017 SHALL, in EXE_IDLE with DecExeValid=1, latch OpClass and MulCycles and go to EXE_ALU (00), EXE_MEM (01/10) or EXE_MUL (11).
REQ-018 SHALL drive SetStallDec combinationally =1 in the acceptance cycle (EXE_IDLE, DecExeValid=1, OpClass!=00), so decode samples it in the same cycle; 0 otherwise.
REQ-019 SHALL, in EXE_ALU, assert AluStart and ExeWbBufferWr for exactly one cycle, then go to EXE_IDLE (ALU op latency: 1 cycle after acceptance).
REQ-020 SHALL, in EXE_MEM, hold MemReq=1 and MemWr=(latched OpClass==10); on MemReady=1 go to EXE_WB, else remain.
REQ-021 SHALL, on entry to EXE_MUL, load a 4-bit down-counter with max(MulCycles,1), pulse AluStart in the first EXE_MUL cycle only, decrement each cycle, and go to EXE_WB in the cycle the counter equals 1.
REQ-022 SHALL, in EXE_WB, assert ExeWbBufferWr and ClrStallDec for one cycle, then go to EXE_IDLE.
REQ-023 SHALL ignore DecExeValid in any state other than EXE_IDLE (no latch, no SetStallDec) and set ExeOverrun=1 until reset.
REQ-024 SHALL ignore MemReady outside EXE_MEM.
REQ-025 SHALL never assert SetStallDec and ClrStallDec in the same cycle.

Reset
REQ-026 SHALL, with RST=1, go to EXE_IDLE next edge from any state, clear counters, latched op and ExeOverrun.
REQ-027 SHALL force all outputs to 0 while RST=1, including combinational SetStallDec; RST wins over simultaneous DecExeValid.
REQ-028 SHALL NOT issue ClrStallDec for an operation aborted by reset.

Configuration
REQ-029 SHALL support macro EXE_MEM_TIMEOUT_EN.
REQ-030 SHALL, when defined, count consecutive EXE_MEM cycles; in the 16th with MemReady=0 assert MemErr and ClrStallDec for that cycle, go to EXE_IDLE, and not write EXE/WB; MemReady=1 in the 16th cycle completes normally.
REQ-031 SHALL, when undefined, wait in EXE_MEM indefinitely and tie MemErr to 0.

Verification
REQ-032 ALU: DecExeValid=1, OpClass=00 -> SetStallDec=0; next cycle AluStart=1, ExeWbBufferWr=1; then IsExeBusy=0.
REQ-033 Load: OpClass=01, MemReady raised 3 cycles after entering EXE_MEM -> SetStallDec=1 at acceptance, MemReq=1 for 4 cycles, MemWr=0, then one cycle ExeWbBufferWr=1, ClrStallDec=1.
REQ-034 Multi-cycle: OpClass=11, MulCycles=5 -> AluStart one cycle, 5 EXE_MUL cycles, then EXE_WB; MulCycles=0 -> 1 EXE_MUL cycle.
REQ-035 Overrun: DecExeValid during EXE_MEM -> no SetStallDec, ExeOverrun=1, held until RST.
REQ-036 Reset mid-op: RST=1 in 2nd EXE_MUL cycle -> EXE_IDLE next edge, all outputs 0, no ClrStallDec.
REQ-037 Timeout (EXE_MEM_TIMEOUT_EN defined): store, MemReady never -> 16th EXE_MEM cycle MemErr=1, ClrStallDec=1, ExeWbBufferWr=0; undefined build -> MemReq stays 1 for 100 cycles.
